// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
//   Shared definitions for the PS/2 keyboard decoder:
//     - scan-code constants for the break/extended prefixes and modifier keys
//     - frame receiver state encoding
//     - 18-bit key event layout {ascii[17:10], scan[9:2], brk[1], ext[0]}
//     - keymap(): scan code set 2 -> lower-case ASCII, 0 = unmapped
//     - is_modifier(): keys that never produce ASCII
// -----------------------------------------------------------------------------
package ps2_pkg;

   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CAPS   = 8'h58;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } frame_state_t;

   typedef struct packed {
      logic [7:0] ascii;
      logic [7:0] scan;
      logic       brk;
      logic       ext;
   } kbd_event_t;

   localparam int EVENT_W = $bits(kbd_event_t);

   // Constant keymap so the design elaborates without an external memory image.
   function automatic logic [7:0] keymap(input logic [7:0] scan);
      logic [7:0] a;
      case (scan)
         8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
         8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
         8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
         8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
         8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
         8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
         8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
         8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
         8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
         8'h3E: a = 8'h38;  8'h46: a = 8'h39;
         8'h29: a = 8'h20;  8'h5A: a = 8'h0D;  8'h66: a = 8'h08;  8'h0D: a = 8'h09;
         8'h76: a = 8'h1B;  8'h41: a = 8'h2C;  8'h49: a = 8'h2E;  8'h4E: a = 8'h2D;
         default: a = 8'h00;
      endcase
      return a;
   endfunction

   function automatic logic is_modifier(input logic [7:0] scan);
      return (scan == SC_LSHIFT) || (scan == SC_RSHIFT) || (scan == SC_CAPS);
   endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// -----------------------------------------------------------------------------
// ps2_event_fifo
//   Show-ahead FIFO for key events. The head entry is presented on o_head
//   while o_empty is low; a pop consumes it. A push while full is accepted
//   only if a pop happens in the same cycle.
//   Ports:
//     clk, clrn        clock, asynchronous active-low reset
//     i_push, i_data   write request and data
//     o_full           no free entry
//     i_pop            consume head (ignored when empty)
//     o_empty          no entry held
//     o_head           current head entry (undefined when empty)
// -----------------------------------------------------------------------------
module ps2_event_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 18
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_full,
   input  logic             i_pop,
   output logic             o_empty,
   output logic [WIDTH-1:0] o_head
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);
   assign o_head    = r_mem[r_rd_ptr];

   // NOTE: storage has no reset; an entry is only observable once the count
   // says it was written, so clearing it would only cost reset fan-out.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

   // NOTE: state is updated with <= so every flop samples pre-edge values;
   // blocking assignments here would make results depend on statement order.
   // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/ps2_kbd_decoder.sv
// -----------------------------------------------------------------------------
// ps2_kbd_decoder
//   PS/2 keyboard receiver and decoder. Synchronises ps2_clk/ps2_data, frames
//   bytes on ps2_clk falling edges (start / 8 data LSB-first / odd parity /
//   stop), folds F0/E0 prefixes into the following key, tracks Shift and
//   CapsLock, maps scan codes to ASCII and queues events for a valid/ready
//   consumer.
//   Ports:
//     clk, clrn                 clock, asynchronous active-low reset
//     ps2_clk, ps2_data         raw keyboard lines (asynchronous)
//     out_valid / out_ready     event handshake; fields are 0 when not valid
//     out_ascii, out_scan       head event ASCII (0 if none) and scan code
//     out_brk, out_ext          head event is a release / carried E0
//     shift, caps               live modifier state
//     frame_err                 1-cycle pulse: bad frame or timeout
//     overflow                  1-cycle pulse: event dropped, queue full
// -----------------------------------------------------------------------------
module ps2_kbd_decoder
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_ascii,
   output logic [7:0] out_scan,
   output logic       out_brk,
   output logic       out_ext,
   output logic       shift,
   output logic       caps,
   output logic       frame_err,
   output logic       overflow
);

   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

   // ---------------- synchroniser and falling-edge detect ----------------
   // Reset to 1 (idle bus level) so releasing reset never fakes an edge.
   logic [SYNC_STAGES-1:0] r_clk_sync;
   logic [SYNC_STAGES-1:0] r_dat_sync;
   logic                   r_clk_last;
   logic                   w_clk_s;
   logic                   w_dat_s;
   logic                   w_fall;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_clk_sync <= '1;
         r_dat_sync <= '1;
         r_clk_last <= 1'b1;
      end else begin
         r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
         r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
         r_clk_last <= w_clk_s;
      end
   end

   assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
   assign w_dat_s = r_dat_sync[SYNC_STAGES-1];
   assign w_fall  = r_clk_last & ~w_clk_s;

   // ---------------- frame FSM ----------------
   frame_state_t r_state;
   frame_state_t w_next_state;
   logic [7:0]   r_sr;
   logic [2:0]   r_bit_cnt;
   logic         r_parity;
   logic [TO_W-1:0] r_to_cnt;
   logic         w_timeout;
   logic         w_byte_done;
   logic         w_err;
   logic         r_byte_vld;
   logic         r_frame_err;

   // Fires on the TIMEOUT_CYC-th consecutive cycle without a fall mid-frame.
   assign w_timeout = (r_state != ST_IDLE) && !w_fall &&
                      (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) r_state <= ST_IDLE;
      else       r_state <= w_next_state;
   end

   // NOTE: every signal written in a combinational block gets a default first;
   // a path that leaves one unassigned would infer a latch.
   always_comb begin
      w_next_state = r_state;
      if (w_timeout) begin
         w_next_state = ST_IDLE;
      end else if (w_fall) begin
         case (r_state)
            ST_IDLE:   if (!w_dat_s) w_next_state = ST_DATA;
            ST_DATA:   if (r_bit_cnt == 3'd7) w_next_state = ST_PARITY;
            ST_PARITY: w_next_state = ST_STOP;
            ST_STOP:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_byte_done = 1'b0;
      w_err       = 1'b0;
      if (w_timeout) begin
         w_err = 1'b1;
      end else if (w_fall) begin
         case (r_state)
            ST_IDLE: w_err = w_dat_s;
            ST_STOP: begin
               // Stop must be 1 and byte+parity must hold an odd number of ones.
               if (w_dat_s && (^{r_sr, r_parity})) w_byte_done = 1'b1;
               else                                 w_err       = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_sr        <= '0;
         r_bit_cnt   <= '0;
         r_parity    <= 1'b0;
         r_to_cnt    <= '0;
         r_byte_vld  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_byte_vld  <= w_byte_done;
         r_frame_err <= w_err;
         if (r_state == ST_IDLE || w_fall || w_timeout) r_to_cnt <= '0;
         else                                            r_to_cnt <= r_to_cnt + TO_W'(1);
         if (w_fall) begin
            case (r_state)
               ST_IDLE:   r_bit_cnt <= '0;
               ST_DATA: begin
                  r_sr      <= {w_dat_s, r_sr[7:1]};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
               end
               ST_PARITY: r_parity <= w_dat_s;
               default:   ;
            endcase
         end
      end
   end

   // ---------------- decoder ----------------
   logic       r_brk;
   logic       r_ext;
   logic       r_shift_on;
   logic       r_caps_on;
   logic       r_caps_held;
   logic [7:0] w_rom;
   logic [7:0] w_ascii;
   logic       w_is_prefix;
   logic       w_push;
   logic       w_pop;
   logic       w_full;
   logic       w_empty;
   kbd_event_t w_event;
   logic [EVENT_W-1:0] w_head_raw;
   kbd_event_t w_head;
   logic       r_overflow;

   assign w_rom       = keymap(r_sr);
   assign w_is_prefix = (r_sr == SC_BREAK) || (r_sr == SC_EXT);
   assign w_push      = r_byte_vld & ~w_is_prefix;
   assign w_pop       = out_ready & ~w_empty;

   // Case folding uses shift/caps as they stood before this event updates them.
   always_comb begin
      w_ascii = 8'h00;
      if (!r_brk && !r_ext && !is_modifier(r_sr)) begin
         w_ascii = w_rom;
         if (w_rom >= 8'h61 && w_rom <= 8'h7A && (r_shift_on ^ r_caps_on))
            w_ascii = w_rom - 8'h20;
      end
   end

   assign w_event = {w_ascii, r_sr, r_brk, r_ext};

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_brk       <= 1'b0;
         r_ext       <= 1'b0;
         r_shift_on  <= 1'b0;
         r_caps_on   <= 1'b0;
         r_caps_held <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_overflow <= w_push & w_full & ~w_pop;
         if (r_byte_vld) begin
            if (r_sr == SC_BREAK) begin
               r_brk <= 1'b1;
            end else if (r_sr == SC_EXT) begin
               r_ext <= 1'b1;
            end else begin
               r_brk <= 1'b0;
               r_ext <= 1'b0;
               // Either Shift key's release clears shift.
               if (!r_ext && (r_sr == SC_LSHIFT || r_sr == SC_RSHIFT))
                  r_shift_on <= ~r_brk;
               // caps_held masks typematic repeats of a held CapsLock.
               if (r_sr == SC_CAPS) begin
                  if (r_brk) begin
                     r_caps_held <= 1'b0;
                  end else if (!r_caps_held) begin
                     r_caps_on   <= ~r_caps_on;
                     r_caps_held <= 1'b1;
                  end
               end
            end
         end
      end
   end

   ps2_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EVENT_W)
   ) u_fifo (
      .clk     (clk),
      .clrn    (clrn),
      .i_push  (w_push),
      .i_data  (w_event),
      .o_full  (w_full),
      .i_pop   (w_pop),
      .o_empty (w_empty),
      .o_head  (w_head_raw)
   );

   assign w_head    = w_empty ? '0 : kbd_event_t'(w_head_raw);
   assign out_valid = ~w_empty;
   assign out_ascii = w_head.ascii;
   assign out_scan  = w_head.scan;
   assign out_brk   = w_head.brk;
   assign out_ext   = w_head.ext;
   assign shift     = r_shift_on;
   assign caps      = r_caps_on;
   assign frame_err = r_frame_err;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// -----------------------------------------------------------------------------
// tb_ps2_kbd_decoder
//   Directed bench: drives PS/2 frames bit by bit and compares every queued
//   event, modifier state and error/overflow pulse count with hand-computed
//   values.
// -----------------------------------------------------------------------------
module tb_ps2_kbd_decoder;

   localparam int DEPTH = 8;
   localparam int TO    = 300;
   localparam int HP    = 8;   // ps2_clk half period in clk cycles

   logic       clk = 1'b0;
   logic       clrn = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_ascii;
   logic [7:0] out_scan;
   logic       out_brk;
   logic       out_ext;
   logic       shift;
   logic       caps;
   logic       frame_err;
   logic       overflow;

   int n_checks = 0;
   int n_errors = 0;
   int n_ferr   = 0;
   int n_ovf    = 0;
   int base_ferr;
   int base_ovf;

   ps2_kbd_decoder #(
      .FIFO_DEPTH  (DEPTH),
      .SYNC_STAGES (2),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk       (clk),
      .clrn      (clrn),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ascii (out_ascii),
      .out_scan  (out_scan),
      .out_brk   (out_brk),
      .out_ext   (out_ext),
      .shift     (shift),
      .caps      (caps),
      .frame_err (frame_err),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   // Pulse counters, sampled on the edge opposite to the one that moves them.
   always @(negedge clk) begin
      if (frame_err) n_ferr++;
      if (overflow)  n_ovf++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ev(input logic [7:0] a, input logic [7:0] s,
                                      input logic b, input logic e);
      return 32'({a, s, b, e});
   endfunction

   task automatic send_bit(input logic b);
      ps2_data = b;
      tick(HP);
      ps2_clk = 1'b0;
      tick(HP);
      ps2_clk = 1'b1;
   endtask

   // Full frame. chk_lat checks out_valid low 3 and high 4 clk edges after the
   // stop-bit falling edge is driven (2 sync stages + byte_vld + FIFO write).
   // pop_on_push raises out_ready exactly for the cycle the event is pushed.
   task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                             input logic pop_on_push, input logic chk_lat);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit((~^b) ^ bad_par);
      ps2_data = ~bad_stop;
      tick(HP);
      ps2_clk = 1'b0;
      tick(3);
      if (chk_lat) check("latency_low", 32'(out_valid), 32'd0);
      if (pop_on_push) out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      if (chk_lat) check("latency_high", 32'(out_valid), 32'd1);
      tick(HP - 4);
      ps2_clk = 1'b1;
      ps2_data = 1'b1;
      tick(HP);
   endtask

   task automatic send(input logic [7:0] b);
      send_frame(b, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pop_expect(input string tag, input logic [31:0] exp);
      int n = 0;
      while (!out_valid && n < 100) begin
         tick(1);
         n++;
      end
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check(tag, 32'({out_ascii, out_scan, out_brk, out_ext}), exp);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
   endtask

   initial begin
      // ---- reset state ----
      tick(3);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_fields", 32'({out_ascii, out_scan, out_brk, out_ext}), 32'd0);
      check("rst_mods", 32'({shift, caps, frame_err, overflow}), 32'd0);
      clrn = 1'b1;
      tick(5);

      // ---- 1: single 'a' with latency ----
      send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b1);
      pop_expect("t1_a", ev(8'h61, 8'h1C, 1'b0, 1'b0));

      // ---- 2: Shift + A, release both ----
      send(8'h12);
      check("t2_shift_on", 32'(shift), 32'd1);
      send(8'h1C);
      send(8'hF0); send(8'h1C);
      check("t2_shift_held", 32'(shift), 32'd1);
      send(8'hF0); send(8'h12);
      check("t2_shift_off", 32'(shift), 32'd0);
      pop_expect("t2_lshift", ev(8'h00, 8'h12, 1'b0, 1'b0));
      pop_expect("t2_A",      ev(8'h41, 8'h1C, 1'b0, 1'b0));
      pop_expect("t2_a_brk",  ev(8'h00, 8'h1C, 1'b1, 1'b0));
      pop_expect("t2_sh_brk", ev(8'h00, 8'h12, 1'b1, 1'b0));

      // ---- 3: CapsLock with typematic repeats ----
      // make toggles 0->1, break, make toggles 1->0, two repeats ignored
      send(8'h58);               check("t3_caps1", 32'(caps), 32'd1);
      send(8'hF0); send(8'h58);  check("t3_caps2", 32'(caps), 32'd1);
      send(8'h58);               check("t3_caps3", 32'(caps), 32'd0);
      send(8'h58);
      send(8'h58);               check("t3_caps_rep", 32'(caps), 32'd0);
      pop_expect("t3_e1", ev(8'h00, 8'h58, 1'b0, 1'b0));
      pop_expect("t3_e2", ev(8'h00, 8'h58, 1'b1, 1'b0));
      pop_expect("t3_e3", ev(8'h00, 8'h58, 1'b0, 1'b0));
      pop_expect("t3_e4", ev(8'h00, 8'h58, 1'b0, 1'b0));
      pop_expect("t3_e5", ev(8'h00, 8'h58, 1'b0, 1'b0));
      // release, press again -> caps 1; then fold with caps, caps^shift
      send(8'hF0); send(8'h58);
      send(8'h58);               check("t3_caps4", 32'(caps), 32'd1);
      send(8'h1C);
      send(8'h12);
      send(8'h1C);
      send(8'hF0); send(8'h12);
      pop_expect("t3_e6",   ev(8'h00, 8'h58, 1'b1, 1'b0));
      pop_expect("t3_e7",   ev(8'h00, 8'h58, 1'b0, 1'b0));
      pop_expect("t3_capA", ev(8'h41, 8'h1C, 1'b0, 1'b0));
      pop_expect("t3_sh",   ev(8'h00, 8'h12, 1'b0, 1'b0));
      pop_expect("t3_both", ev(8'h61, 8'h1C, 1'b0, 1'b0));
      pop_expect("t3_shb",  ev(8'h00, 8'h12, 1'b1, 1'b0));
      send(8'hF0); send(8'h58);
      send(8'h58);               check("t3_caps_off", 32'(caps), 32'd0);
      pop_expect("t3_e8", ev(8'h00, 8'h58, 1'b1, 1'b0));
      pop_expect("t3_e9", ev(8'h00, 8'h58, 1'b0, 1'b0));

      // ---- 4: extended key make/break ----
      send(8'hE0); send(8'h75);
      send(8'hE0); send(8'hF0); send(8'h75);
      send(8'h1C);
      pop_expect("t4_ext_make", ev(8'h00, 8'h75, 1'b0, 1'b1));
      pop_expect("t4_ext_brk",  ev(8'h00, 8'h75, 1'b1, 1'b1));
      pop_expect("t4_plain",    ev(8'h61, 8'h1C, 1'b0, 1'b0));

      // ---- 5: frame errors ----
      base_ferr = n_ferr;
      send_frame(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
      check("t5_par_err", 32'(n_ferr), 32'(base_ferr + 1));
      send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
      check("t5_stop_err", 32'(n_ferr), 32'(base_ferr + 2));
      check("t5_no_event", 32'(out_valid), 32'd0);
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      ps2_data = 1'b1;
      tick(TO + 20);
      check("t5_timeout", 32'(n_ferr), 32'(base_ferr + 3));
      send(8'h32);
      pop_expect("t5_after_to", ev(8'h62, 8'h32, 1'b0, 1'b0));
      check("t5_err_total", 32'(n_ferr), 32'(base_ferr + 3));

      // ---- 6: overflow and pop+push at full ----
      base_ovf = n_ovf;
      send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
      send(8'h24); send(8'h2B); send(8'h34); send(8'h33);
      check("t6_no_ovf_yet", 32'(n_ovf), 32'(base_ovf));
      send(8'h43);
      check("t6_ovf", 32'(n_ovf), 32'(base_ovf + 1));
      send_frame(8'h4B, 1'b0, 1'b0, 1'b1, 1'b0);
      check("t6_pushpop_no_ovf", 32'(n_ovf), 32'(base_ovf + 1));
      pop_expect("t6_b", ev(8'h62, 8'h32, 1'b0, 1'b0));
      pop_expect("t6_c", ev(8'h63, 8'h21, 1'b0, 1'b0));
      pop_expect("t6_d", ev(8'h64, 8'h23, 1'b0, 1'b0));
      pop_expect("t6_e", ev(8'h65, 8'h24, 1'b0, 1'b0));
      pop_expect("t6_f", ev(8'h66, 8'h2B, 1'b0, 1'b0));
      pop_expect("t6_g", ev(8'h67, 8'h34, 1'b0, 1'b0));
      pop_expect("t6_h", ev(8'h68, 8'h33, 1'b0, 1'b0));
      pop_expect("t6_l", ev(8'h6C, 8'h4B, 1'b0, 1'b0));
      check("t6_drained", 32'(out_valid), 32'd0);

      // ---- reset in the middle of a frame ----
      send(8'h12);
      check("rm_shift_set", 32'(shift), 32'd1);
      base_ferr = n_ferr;
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      clrn = 1'b0;
      #2;
      check("rm_valid", 32'(out_valid), 32'd0);
      check("rm_fields", 32'({out_ascii, out_scan, out_brk, out_ext}), 32'd0);
      check("rm_mods", 32'({shift, caps, frame_err, overflow}), 32'd0);
      ps2_data = 1'b1;
      tick(3);
      clrn = 1'b1;
      tick(TO + 20);
      check("rm_no_err", 32'(n_ferr), 32'(base_ferr));
      check("rm_no_event", 32'(out_valid), 32'd0);
      send(8'h1C);
      pop_expect("rm_after", ev(8'h61, 8'h1C, 1'b0, 1'b0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
